// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM encoding, byte-lane masks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STORE,
    ST_LOAD_REQ,
    ST_LOAD_DATA,
    ST_ERR
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shifts the addressed byte/halfword down and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_r_data,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] shifted;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    shifted = mem_r_data >> {off, 3'b000};
    case (funct3)
      F3_B:    rdata = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   rdata = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// RV32 load/store unit in front of the word-addressed unified memory.
// Build option LSU_MISALIGN_TRAP_EN: misaligned LW/LH/LHU/SH raise an error instead of force-aligning.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [XLEN-1:0]   mem_w_data,
  output logic [3:0]        mem_w_mask,
  output logic [ADDR_W-3:0] mem_w_addr,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic              mem_w_en,
  output logic              mem_r_en,
  input  logic [XLEN-1:0]   mem_r_data
);

  localparam int WIDX_W = ADDR_W - 2;
  localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(MEM_DEPTH);

  lsu_state_e        state_q, state_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   w_data_q, w_data_d;
  logic [3:0]        w_mask_q, w_mask_d;
  logic              w_en_q, w_en_d;
  logic              r_en_q, r_en_d;

  logic [WIDX_W-1:0] req_widx;
  logic [1:0]        req_off, eff_off;
  logic              is_word, is_half;
  logic              f3_illegal, range_err, misalign, req_err;
  logic [3:0]        st_mask;
  logic [XLEN-1:0]   st_data;
  logic [XLEN-1:0]   align_rdata;

  // Request decode: legality, effective offset and store lane placement.
  always_comb begin
    req_widx = req_addr[ADDR_W-1:2];
    req_off  = req_addr[1:0];
    is_word  = (req_funct3 == F3_W);
    is_half  = (req_funct3 == F3_H) || (!req_we && req_funct3 == F3_HU);

    if (req_we) f3_illegal = (req_funct3 > F3_W);
    else        f3_illegal = (req_funct3 == 3'd3) || (req_funct3 > F3_HU);
    range_err = (req_widx >= DEPTH_LIM);

`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (is_word && req_off != 2'b00) || (is_half && req_off[0]);
    eff_off  = req_off;
`else
    misalign = 1'b0;
    eff_off  = req_off;
    if (is_word)      eff_off = 2'b00;
    else if (is_half) eff_off[0] = 1'b0;
`endif

    req_err = f3_illegal || range_err || misalign;

    case (req_funct3)
      F3_B: begin
        st_mask = MASK_B0 << eff_off;
        st_data = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        st_mask = eff_off[1] ? MASK_H1 : MASK_H0;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_mask = MASK_W;
        st_data = req_wdata;
      end
    endcase
  end

  // Next-state logic; memory-side controls are computed here and registered.
  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    off_d    = off_q;
    funct3_d = funct3_q;
    w_data_d = w_data_q;
    w_mask_d = w_mask_q;
    w_en_d   = 1'b0;
    r_en_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          widx_d   = req_widx;
          off_d    = eff_off;
          funct3_d = req_funct3;
          if (req_err) begin
            state_d = ST_ERR;
          end else if (req_we) begin
            state_d  = ST_STORE;
            w_en_d   = 1'b1;
            w_data_d = st_data;
            w_mask_d = st_mask;
          end else begin
            state_d = ST_LOAD_REQ;
            r_en_d  = 1'b1;
          end
        end
      end
      ST_LOAD_REQ:  state_d = ST_LOAD_DATA;
      ST_STORE,
      ST_LOAD_DATA,
      ST_ERR:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignment and an async reset, so enables drop the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      widx_q   <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      w_data_q <= '0;
      w_mask_q <= '0;
      w_en_q   <= 1'b0;
      r_en_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      off_q    <= off_d;
      funct3_q <= funct3_d;
      w_data_q <= w_data_d;
      w_mask_q <= w_mask_d;
      w_en_q   <= w_en_d;
      r_en_q   <= r_en_d;
    end
  end

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .mem_r_data (mem_r_data),
    .off        (off_q),
    .funct3     (funct3_q),
    .rdata      (align_rdata)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_STORE) || (state_q == ST_LOAD_DATA) || (state_q == ST_ERR);
  assign rsp_err    = (state_q == ST_ERR);
  assign rsp_rdata  = (state_q == ST_LOAD_DATA) ? align_rdata : '0;
  assign mem_w_en   = w_en_q;
  assign mem_r_en   = r_en_q;
  assign mem_w_data = w_data_q;
  assign mem_w_mask = w_mask_q;
  assign mem_w_addr = widx_q;
  assign mem_r_addr = {2'b00, widx_q};

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a behavioural memory and a response scoreboard.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  localparam int MEM_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_w_mask;
  logic [29:0] mem_w_addr;
  logic [31:0] mem_r_addr;
  logic        mem_w_en, mem_r_en;
  logic [31:0] mem_r_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] mem [0:MEM_DEPTH-1];

  always #5 clk = ~clk;

  lsu_mem_port #(.XLEN(32), .ADDR_W(32), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_w_data (mem_w_data),
    .mem_w_mask (mem_w_mask),
    .mem_w_addr (mem_w_addr),
    .mem_r_addr (mem_r_addr),
    .mem_w_en   (mem_w_en),
    .mem_r_en   (mem_r_en),
    .mem_r_data (mem_r_data)
  );

  // Behavioural memory with byte-masked writes and a registered read port.
  always @(posedge clk) begin
    if (mem_w_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_w_mask[b]) mem[mem_w_addr[9:0]][8*b +: 8] <= mem_w_data[8*b +: 8];
    end
    if (mem_r_en) mem_r_data <= mem[mem_r_addr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("wr_rd_exclusive", {31'b0, mem_w_en & mem_r_en}, 32'd0);
      if (rsp_valid) begin
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("FAIL rsp_unexpected: observed rsp_valid=1 expected no response pending");
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
        end
      end
    end
  end

  // Drives one request and returns 1ns after the accepting edge (cycle T+1).
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk);
    check("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] exp_mask, input logic [31:0] exp_data);
    send(1'b1, f3, addr, wdata, 32'd0, 1'b0);
    check("st_w_en", {31'b0, mem_w_en}, 32'd1);
    check("st_r_en", {31'b0, mem_r_en}, 32'd0);
    check("st_w_addr", {2'b00, mem_w_addr}, {2'b00, addr[31:2]});
    check("st_w_mask", {28'b0, mem_w_mask}, {28'b0, exp_mask});
    check("st_w_data", mem_w_data, exp_data);
    check("st_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("st_req_ready", {31'b0, req_ready}, 32'd0);
    drain();
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp_word_idx,
                      input logic [31:0] exp_rdata);
    send(1'b0, f3, addr, 32'd0, exp_rdata, 1'b0);
    check("ld_r_en_t1", {31'b0, mem_r_en}, 32'd1);
    check("ld_w_en_t1", {31'b0, mem_w_en}, 32'd0);
    check("ld_r_addr", mem_r_addr, exp_word_idx);
    check("ld_rsp_t1", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("ld_r_en_t2", {31'b0, mem_r_en}, 32'd0);
    check("ld_rsp_t2", {31'b0, rsp_valid}, 32'd1);
    drain();
  endtask

  task automatic err_req(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    send(we, f3, addr, 32'hFFFF_FFFF, 32'd0, 1'b1);
    check("err_r_en", {31'b0, mem_r_en}, 32'd0);
    check("err_w_en", {31'b0, mem_w_en}, 32'd0);
    check("err_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("err_rsp_err", {31'b0, rsp_err}, 32'd1);
    drain();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
    check({tag, "_w_en"}, {31'b0, mem_w_en}, 32'd0);
    check({tag, "_r_en"}, {31'b0, mem_r_en}, 32'd0);
    check({tag, "_w_mask"}, {28'b0, mem_w_mask}, 32'd0);
    check({tag, "_w_data"}, mem_w_data, 32'd0);
    check({tag, "_w_addr"}, {2'b00, mem_w_addr}, 32'd0);
    check({tag, "_r_addr"}, mem_r_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    #3;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_reset", {31'b0, req_ready}, 32'd1);

    store(F3_W, 32'h08, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    store(F3_W, 32'h0C, 32'h0000_0000, 4'b1111, 32'h0000_0000);
    store(F3_B, 32'h0D, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
    store(F3_H, 32'h0E, 32'h0000_1234, 4'b1100, 32'h1234_1234);
    load(F3_W, 32'h0C, 32'd3, 32'h1234_A500);

    store(F3_W, 32'h0C, 32'h1280_5678, 4'b1111, 32'h1280_5678);
    load(F3_B,  32'h0E, 32'd3, 32'hFFFF_FF80);
    load(F3_BU, 32'h0E, 32'd3, 32'h0000_0080);
    load(F3_H,  32'h0A, 32'd2, 32'hFFFF_DEAD);
    load(F3_HU, 32'h0A, 32'd2, 32'h0000_DEAD);
    load(F3_W,  32'h08, 32'd2, 32'hDEAD_BEEF);
    load(F3_B,  32'h0C, 32'd3, 32'h0000_0078);

    store(F3_W, 32'h04, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
    err_req(1'b0, F3_W, 32'h06);
    err_req(1'b0, F3_H, 32'h0B);
`else
    load(F3_W, 32'h06, 32'd1, 32'hCAFE_F00D);
    load(F3_H, 32'h0B, 32'd2, 32'hFFFF_DEAD);
`endif

    err_req(1'b0, 3'd3, 32'h08);
    err_req(1'b0, 3'd7, 32'h08);
    err_req(1'b1, 3'd3, 32'h08);
    err_req(1'b0, F3_W, 32'(4 * MEM_DEPTH));
    err_req(1'b1, F3_W, 32'(4 * MEM_DEPTH));
    load(F3_W, 32'(4 * MEM_DEPTH - 4), 32'(MEM_DEPTH - 1), 32'h0000_0000);

    // Reset asserted while the load sits in LOAD_DATA; its response must vanish.
    send(1'b0, F3_W, 32'h08, 32'd0, 32'hDEAD_BEEF, 1'b0);
    check("rst_ld_r_en", {31'b0, mem_r_en}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_midrst", {31'b0, req_ready}, 32'd1);

    store(F3_W, 32'h10, 32'h55AA_33CC, 4'b1111, 32'h55AA_33CC);
    load(F3_W, 32'h10, 32'd4, 32'h55AA_33CC);

    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit that sits directly upstream of the unified code/data memory.
- Converts a byte-addressed RV32 load/store request from the execute stage (funct3 LB/LH/LW/LBU/LHU/SB/SH/SW) into word-addressed memory accesses with byte write masks.
- Extracts, aligns and sign/zero-extends load data coming back from the memory's registered read port.
- Returns one response per request to the core.

Parameters:
- XLEN, 32, data width; equals memory word width.
- ADDR_W, 32, byte address width of requests.
- MEM_DEPTH, 1024, memory depth in words; word index >= MEM_DEPTH is out of range.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid&&req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3 (load: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; store: 0 SB, 1 SH, 2 SW).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store source register value.
- rsp_valid  out  1  one-cycle response pulse; core always accepts, no backpressure.
- rsp_rdata  out  XLEN  load result; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid.
- mem_w_data  out  XLEN  lane-replicated store data.
- mem_w_mask  out  4  byte enables.
- mem_w_addr  out  ADDR_W-2  word index.
- mem_r_addr  out  ADDR_W  word index, zero-extended.
- mem_w_en  out  1  memory write enable.
- mem_r_en  out  1  memory read enable.
- mem_r_data  in  XLEN  memory read data, valid the cycle after mem_r_en.

Behaviour:
- States: IDLE, STORE, LOAD_REQ, LOAD_DATA, ERR. All memory-side outputs are registered from the latched request.
- Accept in cycle T (IDLE only):
  - Store -> STORE.
  - Legal load -> LOAD_REQ.
  - Error -> ERR.
- STORE (T+1):
  - mem_w_en=1, rsp_valid=1, rsp_err=0 -> IDLE.
  - Throughput: one store per 2 cycles.
- LOAD_REQ (T+1): mem_r_en=1 -> LOAD_DATA.
- LOAD_DATA (T+2):
  - rsp_valid=1; rsp_rdata is combinationally extracted from mem_r_data -> IDLE.
  - Throughput: one load per 3 cycles.
- ERR (T+1): rsp_valid=1, rsp_err=1, rsp_rdata=0, no memory enable -> IDLE.
- Word index = req_addr[ADDR_W-1:2]; off = req_addr[1:0].
- Store lanes:
  - SB: mask = 1<<off, data = {4{wdata[7:0]}}.
  - SH: mask = off[1] ? 1100 : 0011, data = {2{wdata[15:0]}}.
  - SW: mask = 1111, data = wdata.
- Load extract:
  - s = mem_r_data >> (8*off).
  - LB/LH sign-extend s[7:0]/s[15:0]; LBU/LHU zero-extend; LW passes the word.
- Error conditions (always active):
  - Illegal funct3: loads 3, 6, 7; stores >= 3.
  - Word index >= MEM_DEPTH.
- mem_w_en and mem_r_en are never both high; each is high for exactly one cycle per access.
- Requests arriving while busy are not accepted (req_ready=0); the core holds them.
- Reset values:
  - State IDLE; req_ready=1 once reset releases.
  - All other outputs 0, including mem_* data, address and mask.
- Reset mid-operation:
  - Enables drop immediately (async), so no write occurs at the next edge.
  - Any pending response is discarded.

Optional Feature:
- LSU_MISALIGN_TRAP_EN
- Defined:
  - LW with off!=0, and LH/LHU/SH with off[0]=1, are errors -> ERR; no memory access.
  - SB/LB/LBU are never misaligned.
- Undefined:
  - Misaligned accesses are force-aligned: off cleared to 0 for words; off[0] cleared for halfwords.
  - No error is raised for misalignment.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding.
  - Mask constants MASK_B0, MASK_H0, MASK_H1, MASK_W.
- Sub-module lsu_load_align: purely combinational (mem_r_data, off, funct3) -> rsp_rdata; instantiated once.
- Store-lane logic stays in lsu_mem_port.

Test Plan:
1. SW addr 0x08 data 0xDEADBEEF -> at T+1: mem_w_en=1, mem_w_addr=2, mask 1111, w_data 0xDEADBEEF, rsp_valid=1, rsp_err=0.
2. SB addr 0x0D data 0x000000A5 -> mem_w_addr=3, mask 0010, w_data 0xA5A5A5A5. SH addr 0x0E data 0x1234 -> mask 1100, w_data 0x12341234.
3. Memory word 3 = 0x12805678. LB addr 0x0E -> mem_r_en at T+1, rsp_valid at T+2, rdata 0xFFFFFF80. LBU same addr -> 0x00000080.
4. Memory word 2 = 0xDEADBEEF.
   - LH addr 0x0A -> 0xFFFFDEAD.
   - LHU -> 0x0000DEAD.
   - LW addr 0x08 -> 0xDEADBEEF.
5. LW addr 0x06:
   - With macro -> no mem_r_en, rsp_err=1 at T+1.
   - Without macro -> reads word 1, rsp_err=0.
   - Load funct3=3 or address 4*MEM_DEPTH -> rsp_err=1 regardless of macro.
6. rst_n low during LOAD_DATA -> all outputs 0 immediately, no rsp_valid. After release, req_ready=1 and the next SW completes normally.
